leaf_fpga_controller: RTL and testbench
=======================================

Name: leaf_fpga_controller

Overview:
- Child-side endpoint of the root/child control-FIFO protocol; one instance per child FPGA.
- Accepts 64-bit control messages addressed to its FPGA_ID or broadcast (8'hFF) and drives the local decoding array.
- Times each decode and returns one HEADER_RESULT message per decode block upstream to the root.
- Header codes come from the shared parameters include.

Parameters:
- FPGA_ID, 8'h01, this child's destination address; never 8'h00 or 8'hFF.
- CTRL_FIFO_WIDTH, 64, control message width.
- ITERATION_COUNTER_WIDTH, 8, saturating count of decode cycles.
- MAXIMUM_DELAY, 2, quiet cycles required on decoder_busy and router_busy before convergence.
- TIMEOUT_CYCLES, 16'hFFFF, decode watchdog limit; used only with DECODE_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- data_from_parent  in  64  message from root; dest [63:56], header [55:48], payload [47:0]
- valid_from_parent  in  1  message valid
- ready_from_parent  out  1  message accepted when valid&&ready
- data_to_parent  out  64  upstream message
- valid_to_parent  out  1  upstream valid
- ready_to_parent  in  1  upstream ready
- start_decoding  out  1  one-cycle pulse to local array
- boundary_data  out  48  payload of last SET_BOUNDARIES
- boundary_valid  out  1  one-cycle pulse with boundary_data
- decoder_busy  in  1  local array still growing/merging
- router_busy  in  1  inter-FPGA router holding traffic

Behaviour:
- Reset values: ready_from_parent=0, valid_to_parent=0, data_to_parent=0, start_decoding=0, boundary_valid=0, boundary_data=0. State=IDLE. Counters=0. report_flag=0.
- Address match: dest==FPGA_ID or dest==8'hFF. Non-matching messages in IDLE are accepted and dropped.
- IDLE: ready_from_parent=1. A matching message is handled on the handshake cycle by header:
  - HEADER_RESET_CLOCK: cycle_counter<=0.
  - HEADER_SET_BOUNDARIES: boundary_data<=[47:0]; boundary_valid pulses on the next cycle.
  - HEADER_INITIALIZE_DECODING: iteration_counter<=0; no state change.
  - HEADER_DECODE_BLOCK: report_flag<=bit[2]; start_decoding pulses on the next cycle; latency<=0; go DECODE.
  - Any other header: dropped.
- ready_from_parent=0 in all states except IDLE. Messages arriving mid-decode are backpressured, not lost.
- cycle_counter: 16-bit free-running, wraps 16'hFFFF->0. Any reset, including reset mid-decode, returns to IDLE with all outputs at reset values.
- DECODE:
  - latency increments every cycle, 16-bit, wraps.
  - iteration_counter increments every cycle and saturates at all-ones.
  - quiet_cnt is cleared whenever decoder_busy||router_busy, otherwise increments.
  - When quiet_cnt reaches MAXIMUM_DELAY, go SETTLE.
  - decoder_busy is ignored for the first 2 cycles after start_decoding (array startup).
- SETTLE (1 cycle): if report_flag, build the result message and go REPORT; else go IDLE.
- Result message layout:
  - [63:56]=8'h00
  - [55:48]=HEADER_RESULT
  - [47:40]=FPGA_ID
  - [39:32]=iteration_counter (zero-extended)
  - [31:17]=0
  - [16]=timeout flag
  - [15:0]=latency
- REPORT: valid_to_parent=1 with data held stable until ready_to_parent. Go IDLE on the handshake cycle. valid_to_parent must not drop before the handshake.
- Minimum latency from DECODE_BLOCK accept to valid_to_parent: 1 (pulse) + MAXIMUM_DELAY + 2 startup + 1 SETTLE cycles.
- Reporting as many as 3 FPGAs' latencies and returning a count is the root's responsibility. This block emits exactly one result per reported block.

Optional Feature:
- DECODE_TIMEOUT_EN defined: in DECODE, if latency==TIMEOUT_CYCLES, force SETTLE with the timeout flag bit[16]=1.
- If report_flag=0, a timeout still returns to IDLE silently.
- Undefined: no watchdog, bit[16] always 0, TIMEOUT_CYCLES unused; DECODE can last indefinitely.

Test Plan:
- Reset, then DECODE_BLOCK dest 8'hFF with bit2=1, decoder_busy high 10 cycles, router_busy low, MAXIMUM_DELAY=2 -> one start_decoding pulse; one result with [63:56]=0, [55:48]=HEADER_RESULT, [47:40]=FPGA_ID, latency 12.
- SET_BOUNDARIES dest FPGA_ID payload 48'h0000_00AB_CDEF -> boundary_valid pulses 1 cycle with that value. Same message with dest 8'h07 (≠FPGA_ID) -> accepted, no pulse.
- Hold ready_to_parent=0 for 20 cycles during REPORT -> valid_to_parent and data stable throughout; single handshake; then ready_from_parent=1.
- DECODE_BLOCK with bit2=0 -> decode runs, no upstream message. A message sent mid-decode sees ready_from_parent=0 and is accepted only after IDLE.
- RESET_CLOCK, then 70000 idle cycles -> cycle_counter wraps correctly. Reset asserted mid-DECODE -> all outputs zero next cycle, no result emitted.
- With DECODE_TIMEOUT_EN, TIMEOUT_CYCLES=100, decoder_busy stuck high -> result at latency 100 with bit[16]=1.

Source files
------------

// File: rtl/leaf_fpga_controller.sv
// leaf_fpga_controller: child-side endpoint of the root/child control-FIFO link.
// Accepts control messages addressed to FPGA_ID or broadcast, drives the local
// decoding array, times each decode and returns one HEADER_RESULT upstream per
// reported decode block.
// Optional feature macro: DECODE_TIMEOUT_EN (decode watchdog of TIMEOUT_CYCLES).
// Header codes mirror the shared parameters include of the root/child protocol.
module leaf_fpga_controller #(
    parameter logic [7:0]  FPGA_ID                 = 8'h01,
    parameter int          CTRL_FIFO_WIDTH         = 64,
    parameter int          ITERATION_COUNTER_WIDTH = 8,
    parameter int          MAXIMUM_DELAY           = 2,
    parameter logic [15:0] TIMEOUT_CYCLES          = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CTRL_FIFO_WIDTH-1:0] data_from_parent,
    input  logic                       valid_from_parent,
    output logic                       ready_from_parent,
    output logic [CTRL_FIFO_WIDTH-1:0] data_to_parent,
    output logic                       valid_to_parent,
    input  logic                       ready_to_parent,
    output logic                       start_decoding,
    output logic [47:0]                boundary_data,
    output logic                       boundary_valid,
    input  logic                       decoder_busy,
    input  logic                       router_busy
);

    localparam logic [7:0] HEADER_RESET_CLOCK         = 8'h01;
    localparam logic [7:0] HEADER_SET_BOUNDARIES      = 8'h02;
    localparam logic [7:0] HEADER_INITIALIZE_DECODING = 8'h03;
    localparam logic [7:0] HEADER_DECODE_BLOCK        = 8'h04;
    localparam logic [7:0] HEADER_RESULT              = 8'h05;
    localparam logic [7:0] BROADCAST_ID               = 8'hFF;

    typedef enum logic [1:0] {IDLE, DECODE, SETTLE, REPORT} state_t;

    state_t state, next_state;

    logic [15:0]                        cycle_counter;
    logic [15:0]                        latency;
    logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
    logic [7:0]                         quiet_cnt;
    logic [1:0]                         startup_cnt;
    logic                               report_flag;
    logic                               timeout_flag;
    logic                               timeout_hit;
    logic                               msg_accept;
    logic                               converged;
    logic                               startup_done;

    wire [7:0]  msg_dest    = data_from_parent[63:56];
    wire [7:0]  msg_header  = data_from_parent[55:48];
    wire [47:0] msg_payload = data_from_parent[47:0];
    wire        addr_match  = (msg_dest == FPGA_ID) || (msg_dest == BROADCAST_ID);
    wire        any_busy    = decoder_busy || router_busy;

    // The pulse cycle plus two array-startup cycles never count as quiet.
    assign startup_done = (startup_cnt == 2'd3);

`ifdef DECODE_TIMEOUT_EN
    assign timeout_hit = (state == DECODE) && (latency == TIMEOUT_CYCLES);
`else
    assign timeout_hit = 1'b0;
    // Watchdog is compiled out; TIMEOUT_CYCLES is deliberately left unreferenced.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic, handshake qualification and convergence detection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        next_state        = state;
        ready_from_parent = (state == IDLE) && !reset;
        msg_accept        = ready_from_parent && valid_from_parent && addr_match;
        converged         = (state == DECODE) && startup_done && !any_busy &&
                            ((quiet_cnt + 8'd1) == 8'(MAXIMUM_DELAY));
        case (state)
            IDLE:    if (msg_accept && msg_header == HEADER_DECODE_BLOCK) next_state = DECODE;
            DECODE:  if (timeout_hit || converged) next_state = SETTLE;
            SETTLE:  next_state = report_flag ? REPORT : IDLE;
            REPORT:  if (ready_to_parent) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Message handling, decode timing counters and upstream result register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            cycle_counter     <= '0;
            latency           <= '0;
            iteration_counter <= '0;
            quiet_cnt         <= '0;
            startup_cnt       <= '0;
            report_flag       <= 1'b0;
            timeout_flag      <= 1'b0;
            start_decoding    <= 1'b0;
            boundary_valid    <= 1'b0;
            boundary_data     <= '0;
            valid_to_parent   <= 1'b0;
            data_to_parent    <= '0;
        end else begin
            start_decoding <= 1'b0;
            boundary_valid <= 1'b0;
            cycle_counter  <= cycle_counter + 16'd1;

            if (msg_accept) begin
                case (msg_header)
                    HEADER_RESET_CLOCK: cycle_counter <= '0;
                    HEADER_SET_BOUNDARIES: begin
                        boundary_data  <= msg_payload;
                        boundary_valid <= 1'b1;
                    end
                    HEADER_INITIALIZE_DECODING: iteration_counter <= '0;
                    HEADER_DECODE_BLOCK: begin
                        report_flag    <= data_from_parent[2];
                        start_decoding <= 1'b1;
                        latency        <= '0;
                        quiet_cnt      <= '0;
                        startup_cnt    <= '0;
                        timeout_flag   <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (state == DECODE) begin
                if (timeout_hit) timeout_flag <= 1'b1;
                else             latency      <= latency + 16'd1;
                if (iteration_counter != '1)
                    iteration_counter <= iteration_counter + ITERATION_COUNTER_WIDTH'(1);
                if (!startup_done) startup_cnt <= startup_cnt + 2'd1;
                if (!startup_done || any_busy) quiet_cnt <= '0;
                else                           quiet_cnt <= quiet_cnt + 8'd1;
            end

            if (state == SETTLE && report_flag) begin
                data_to_parent  <= {8'h00, HEADER_RESULT, FPGA_ID, 8'(iteration_counter),
                                    15'd0, timeout_flag, latency};
                valid_to_parent <= 1'b1;
            end

            if (state == REPORT && ready_to_parent) valid_to_parent <= 1'b0;
        end
    end

endmodule

// File: tb/tb_leaf_fpga_controller.sv
// Self-checking bench for leaf_fpga_controller: directed steps plus randomized
// decode blocks checked against a cycle-count model of the decode rules.
module tb_leaf_fpga_controller;

    localparam logic [7:0] FPGA_ID  = 8'h01;
    localparam int         MAXD     = 2;
    localparam int         TIMEOUT  = 100;
    localparam int         NBUSY    = 512;

    localparam logic [7:0] HDR_RESET_CLOCK = 8'h01;
    localparam logic [7:0] HDR_SET_BOUND   = 8'h02;
    localparam logic [7:0] HDR_INIT_DEC    = 8'h03;
    localparam logic [7:0] HDR_DECODE      = 8'h04;
    localparam logic [7:0] HDR_RESULT      = 8'h05;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] data_from_parent;
    logic        valid_from_parent;
    logic        ready_from_parent;
    logic [63:0] data_to_parent;
    logic        valid_to_parent;
    logic        ready_to_parent;
    logic        start_decoding;
    logic [47:0] boundary_data;
    logic        boundary_valid;
    logic        decoder_busy;
    logic        router_busy;

    int tests    = 0;
    int failures = 0;

    // Reference state kept by the bench.
    int          exp_iter     = 0;
    logic [47:0] exp_boundary = '0;
    bit          dbusy [NBUSY];
    bit          rbusy [NBUSY];

    leaf_fpga_controller #(
        .FPGA_ID(FPGA_ID), .CTRL_FIFO_WIDTH(64), .ITERATION_COUNTER_WIDTH(8),
        .MAXIMUM_DELAY(MAXD), .TIMEOUT_CYCLES(16'(TIMEOUT))
    ) dut (
        .clk(clk), .reset(reset),
        .data_from_parent(data_from_parent), .valid_from_parent(valid_from_parent),
        .ready_from_parent(ready_from_parent),
        .data_to_parent(data_to_parent), .valid_to_parent(valid_to_parent),
        .ready_to_parent(ready_to_parent),
        .start_decoding(start_decoding),
        .boundary_data(boundary_data), .boundary_valid(boundary_valid),
        .decoder_busy(decoder_busy), .router_busy(router_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_busy();
        for (int k = 0; k < NBUSY; k++) begin
            dbusy[k] = 1'b0;
            rbusy[k] = 1'b0;
        end
    endfunction

    // Decode cycle k (1 = start pulse cycle) at which the block converges:
    // cycles 1..3 never count, then MAXD consecutive cycles with both busies low.
    function automatic int conv_index();
        int run = 0;
        for (int k = 1; k < NBUSY; k++) begin
            if (k >= 4 && !dbusy[k] && !rbusy[k]) run++;
            else                                  run = 0;
            if (run == MAXD) return k;
        end
        return 1_000_000;
    endfunction

    task automatic send_msg(input logic [7:0] dest, input logic [7:0] hdr, input logic [47:0] pl);
        int w = 0;
        data_from_parent  = {dest, hdr, pl};
        valid_from_parent = 1'b1;
        while (!ready_from_parent && w < 50) begin
            tick();
            w++;
        end
        check("send_ready_wait", 96'(w < 50), 96'd1);
        tick();
        valid_from_parent = 1'b0;
    endtask

    // Runs one DECODE_BLOCK with the busy pattern currently in dbusy/rbusy.
    task automatic run_decode(input logic [7:0] dest, input bit report, input bit mid_msg,
                              input int hold);
        int          conv, lat, ncyc, done_at, pulses, ready_hi;
        bit          tflag;
        logic [63:0] exp_msg;
        logic [47:0] mid_pl;
        conv  = conv_index();
        lat   = conv;
        ncyc  = conv;
        tflag = 1'b0;
`ifdef DECODE_TIMEOUT_EN
        if (conv > TIMEOUT) begin
            lat   = TIMEOUT;
            ncyc  = TIMEOUT + 1;
            tflag = 1'b1;
        end
`endif
        exp_iter = (exp_iter + ncyc > 255) ? 255 : exp_iter + ncyc;
        exp_msg  = {8'h00, HDR_RESULT, FPGA_ID, 8'(exp_iter), 15'd0, tflag, 16'(lat)};
        mid_pl   = {16'h0, $urandom()};

        send_msg(dest, HDR_DECODE, {45'd0, report, 2'b00});
        done_at  = 0;
        pulses   = 0;
        ready_hi = 0;
        for (int k = 1; k < NBUSY + 50 && done_at == 0; k++) begin
            decoder_busy = (k < NBUSY) ? dbusy[k] : 1'b0;
            router_busy  = (k < NBUSY) ? rbusy[k] : 1'b0;
            if (mid_msg) begin
                data_from_parent  = {FPGA_ID, HDR_SET_BOUND, mid_pl};
                valid_from_parent = 1'b1;
            end
            if (start_decoding) pulses++;
            if (ready_from_parent) ready_hi++;
            tick();
            if (valid_to_parent || ready_from_parent) done_at = k;
        end
        decoder_busy = 1'b0;
        router_busy  = 1'b0;
        check("decode_done_cycle", 96'(done_at), 96'(ncyc + 1));
        check("start_pulse_count", 96'(pulses), 96'd1);
        check("ready_low_in_decode", 96'(ready_hi), 96'd0);

        if (report) begin
            check("result_valid", 96'(valid_to_parent), 96'd1);
            check("result_data", 96'(data_to_parent), 96'(exp_msg));
            ready_to_parent = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                check("report_hold", {31'd0, valid_to_parent, data_to_parent}, {31'd0, 1'b1, exp_msg});
            end
            ready_to_parent = 1'b1;
            tick();
            ready_to_parent = 1'b0;
            check("report_drop_after_hs", 96'(valid_to_parent), 96'd0);
            check("ready_after_report", 96'(ready_from_parent), 96'd1);
        end else begin
            check("no_upstream_msg", 96'(valid_to_parent), 96'd0);
            if (mid_msg) begin
                // Pending message is taken on the first IDLE cycle.
                tick();
                valid_from_parent = 1'b0;
                exp_boundary      = mid_pl;
                check("mid_msg_bvalid", 96'(boundary_valid), 96'd1);
                check("mid_msg_bdata", 96'(boundary_data), 96'(exp_boundary));
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        data_from_parent  = '0;
        valid_from_parent = 1'b0;
        ready_to_parent   = 1'b0;
        decoder_busy      = 1'b0;
        router_busy       = 1'b0;
        repeat (3) tick();
        check("rst_ready", 96'(ready_from_parent), 96'd0);
        check("rst_valid", 96'(valid_to_parent), 96'd0);
        check("rst_data", 96'(data_to_parent), 96'd0);
        check("rst_start", 96'(start_decoding), 96'd0);
        check("rst_bvalid", 96'(boundary_valid), 96'd0);
        check("rst_bdata", 96'(boundary_data), 96'd0);
        reset = 1'b0;
        tick();
        check("idle_ready", 96'(ready_from_parent), 96'd1);

        // Broadcast decode, decoder_busy high for 10 cycles, report held 20 cycles.
        clear_busy();
        for (int k = 1; k <= 10; k++) dbusy[k] = 1'b1;
        check("tp1_model_latency", 96'(conv_index()), 96'd12);
        run_decode(8'hFF, 1'b1, 1'b0, 20);

        // Fastest possible decode.
        clear_busy();
        run_decode(FPGA_ID, 1'b1, 1'b0, 0);

        // SET_BOUNDARIES to this FPGA, then the same to another FPGA.
        send_msg(FPGA_ID, HDR_SET_BOUND, 48'h0000_00AB_CDEF);
        exp_boundary = 48'h0000_00AB_CDEF;
        check("bound_pulse", 96'(boundary_valid), 96'd1);
        check("bound_data", 96'(boundary_data), 96'(exp_boundary));
        tick();
        check("bound_pulse_width", 96'(boundary_valid), 96'd0);
        send_msg(8'h07, HDR_SET_BOUND, 48'h0000_1234_5678);
        check("foreign_no_pulse", 96'(boundary_valid), 96'd0);
        check("foreign_data_kept", 96'(boundary_data), 96'(exp_boundary));

        // Foreign DECODE_BLOCK is dropped.
        send_msg(8'h07, HDR_DECODE, 48'h4);
        check("foreign_dec_no_start", 96'(start_decoding), 96'd0);
        check("foreign_dec_idle", 96'(ready_from_parent), 96'd1);

        // Unreported decode with a message pending mid-decode.
        clear_busy();
        for (int k = 1; k <= 6; k++) dbusy[k] = 1'b1;
        rbusy[8] = 1'b1;
        run_decode(FPGA_ID, 1'b0, 1'b1, 0);

        // Iteration counter restart, then randomized decode blocks.
        send_msg(8'hFF, HDR_INIT_DEC, 48'h0);
        exp_iter = 0;
        for (int n = 0; n < 8; n++) begin
            int dlen, rlen;
            clear_busy();
            dlen = $urandom_range(0, 15);
            rlen = $urandom_range(0, 15);
            for (int k = 1; k <= dlen; k++) dbusy[k] = 1'b1;
            for (int k = 1; k <= rlen; k++) rbusy[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                send_msg(FPGA_ID, HDR_INIT_DEC, 48'h0);
                exp_iter = 0;
            end
            run_decode(($urandom_range(0, 1) == 1) ? 8'hFF : FPGA_ID,
                       1'($urandom_range(0, 3) != 0), 1'b0, $urandom_range(0, 4));
        end

        // Long decode drives the iteration counter into saturation.
        clear_busy();
        for (int k = 1; k <= 260; k++) dbusy[k] = 1'b1;
        run_decode(FPGA_ID, 1'b1, 1'b0, 1);

`ifdef DECODE_TIMEOUT_EN
        // decoder_busy stuck high: watchdog ends the block at latency TIMEOUT.
        send_msg(FPGA_ID, HDR_INIT_DEC, 48'h0);
        exp_iter = 0;
        clear_busy();
        for (int k = 1; k < NBUSY; k++) dbusy[k] = 1'b1;
        run_decode(FPGA_ID, 1'b1, 1'b0, 2);
`endif

        // Reset in the middle of a decode.
        decoder_busy = 1'b1;
        send_msg(FPGA_ID, HDR_DECODE, 48'h4);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_ready", 96'(ready_from_parent), 96'd0);
        check("midrst_valid", 96'(valid_to_parent), 96'd0);
        check("midrst_data", 96'(data_to_parent), 96'd0);
        check("midrst_start", 96'(start_decoding), 96'd0);
        check("midrst_bvalid", 96'(boundary_valid), 96'd0);
        check("midrst_bdata", 96'(boundary_data), 96'd0);
        reset        = 1'b0;
        decoder_busy = 1'b0;
        exp_iter     = 0;
        exp_boundary = '0;
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (valid_to_parent) seen++;
            end
            check("midrst_no_result", 96'(seen), 96'd0);
        end
        check("midrst_idle", 96'(ready_from_parent), 96'd1);

        // Decode after the reset restarts the iteration count from zero.
        clear_busy();
        run_decode(FPGA_ID, 1'b1, 1'b0, 0);

        // RESET_CLOCK followed by a long idle stretch across the 16-bit wrap.
        send_msg(FPGA_ID, HDR_RESET_CLOCK, 48'h0);
        check("cycle_cnt_cleared", 96'(dut.cycle_counter), 96'd0);
        repeat (70000) @(posedge clk);
        #1;
        check("cycle_cnt_wrap", 96'(dut.cycle_counter), 96'(16'(70000)));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
